turbo_encoder: RTL and testbench
================================

Name: turbo_encoder

Overview:
- Rate-1/3-plus-tail parallel-concatenated turbo encoder; it is the transmit-side counterpart of the team's max-log-MAP SISO decoder.
- Takes a 5-bit message and runs two identical 4-state RSC encoders: encoder 1 on natural order, encoder 2 on interleaved order.
- Each encoder is terminated with 2 tail bits, giving 7 symbols per stream.
- Emits four 28-bit buses of 4-bit signed antipodal soft symbols, directly consumable as sys_i / enc_i of the decoder.

Parameters:
- INPUT_SIZE, 5: message bits per block.
- EXTEND_SIZE, 7: INPUT_SIZE + 2 tail steps.
- SYM_W, 4: soft symbol width, signed.
- AMP, 7: symbol magnitude. Bit 1 -> +AMP (4'b0111); bit 0 -> -AMP (4'b1001).
- PERM, {3'd2,3'd1,3'd4,3'd0,3'd3}: interleaver table, pi(i) = PERM[3i+2:3i]. Default pi = (3,0,4,1,2).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- read_en_i  in  1  start request; sampled only when idle.
- data_i  in  5  message; u[k] = data_i[k].
- sys_o  out  28  systematic stream, natural order incl. encoder-1 tail.
- enc1_o  out  28  encoder-1 parity.
- sys2_o  out  28  interleaved systematic incl. encoder-2 tail.
- enc2_o  out  28  encoder-2 parity.
- busy_o  out  1  encoding in progress.
- finish_o  out  1  one-cycle pulse; all buses are final.

Behaviour:
- Reset (async, active-high): state IDLE, cnt 0, both RSC states 0, all buses 0, busy_o 0, finish_o 0. Reset mid-block aborts immediately; no finish_o follows.
- Symbol packing: symbol k occupies bits [27-4k:24-4k], so symbol 0 is in the MSB nibble.
- RSC trellis, state {m1,m0}, index = 2*m1 + m0:
  - a = u ^ m0
  - parity p = a
  - next state = {a, m1}
  - This matches the decoder trellis: 0->0/2, 1->0/2, 2->1/3, 3->1/3.
- Termination (steps 5 and 6): u = m0, forcing a = 0, so p = 0 and the state reaches 0 after 2 steps. The tail u is emitted on that encoder's systematic bus.
- Encoder 2 input: u2[k] = u[pi(k)] for k < 5; its tail is computed from its own state.
- FSM states IDLE, ENCODE, DONE:
  - IDLE, edge E0 with read_en_i=1: latch data_i, clear all buses, reset both RSC states, cnt=0, busy_o=1, go to ENCODE. With read_en_i=0, stay in IDLE.
  - ENCODE, edges E1..E7: process step cnt (0..6), write symbol cnt on all four buses, update RSC states, cnt++. At E7 (cnt=6) go to DONE.
  - DONE: finish_o=1 and busy_o=0 for exactly this one cycle; next edge returns to IDLE. read_en_i is not accepted in DONE.
- Latency: finish_o rises 7 cycles after the accepting edge; back-to-back blocks accept every 9 cycles.
- read_en_i while busy or in DONE is ignored; no queuing.
- data_i changes after E0 have no effect.
- Buses hold their final value from E7 until the next accepted start (cleared at that E0). Partial values are visible during ENCODE; consumers must qualify with finish_o.
- Both encoder final states are 0 at DONE; simulation assertion.

Decomposition:
- Package turbo_pkg holds:
  - INPUT_SIZE, EXTEND_SIZE, SYM_W, AMP constants.
  - FSM state encoding, 2-bit.
  - Functions rsc_next(state,u), rsc_parity(state,u), bit_to_sym(bit).
- Sub-module rsc_core, instantiated twice: holds the 2-bit state register, takes u plus a term flag (term selects u = m0), and outputs sys bit, parity bit, and current state.

Test Plan:
- data_i=5'b00000 -> at finish_o: sys_o = enc1_o = sys2_o = enc2_o = 28'h9999999; finish_o high for 1 cycle, 7 cycles after accept.
- data_i=5'b00001 -> sys_o=28'h7999997, enc1_o=28'h7979799, sys2_o=28'h9799979, enc2_o=28'h9797999.
- Random data_i x1000 against a reference model -> bit-exact buses; both RSC end states 0; each stream feeds the SISO decoder and hard decisions equal data_i at high SNR.
- reset_i pulsed in the 3rd ENCODE cycle -> buses 0, busy_o 0, no finish_o; next start encodes correctly.
- read_en_i held high continuously -> accepts every 9 cycles; a read_en_i pulse mid-block is ignored and buses remain from the first block.
- data_i toggled every cycle after acceptance -> output equals encoding of the value latched at E0.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder.
// Holds block and symbol sizing constants, the controller state encoding,
// and small helpers for the 4-state RSC trellis and the antipodal
// soft-symbol mapping.
package turbo_pkg;

  localparam int INPUT_SIZE  = 5;               // message bits per block
  localparam int EXTEND_SIZE = INPUT_SIZE + 2;  // message plus two tail steps
  localparam int SYM_W       = 4;               // signed soft symbol width
  localparam int AMP         = 7;               // symbol magnitude
  localparam int CNT_W       = 3;               // step counter width (0..6)
  localparam int BUS_W       = EXTEND_SIZE * SYM_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_DONE   = 2'd2
  } fsm_state_e;

  // Trellis state is {m1, m0}; the feedback bit a = u ^ m0 is shifted in at m1.
  function automatic logic [1:0] rsc_next(input logic [1:0] state, input logic u);
    return {u ^ state[0], state[1]};
  endfunction

  // Parity equals the feedback bit.
  function automatic logic rsc_parity(input logic [1:0] state, input logic u);
    return u ^ state[0];
  endfunction

  // Bit 1 -> +AMP, bit 0 -> -AMP in two's complement.
  function automatic logic [SYM_W-1:0] bit_to_sym(input logic b);
    logic [SYM_W-1:0] mag;
    mag = SYM_W'(AMP);
    return b ? mag : (~mag + 1'b1);
  endfunction

  // LSB position of symbol k on a bus; symbol 0 sits in the MSB nibble.
  function automatic int sym_lsb(input logic [CNT_W-1:0] k);
    return SYM_W * (EXTEND_SIZE - 1 - int'(k));
  endfunction

endpackage

// File: rtl/turbo_encoder_rsc_core.sv
// One 4-state recursive systematic convolutional encoder.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : synchronously return the trellis state to 0
//   step_i         : advance the trellis by one input bit
//   u_i            : message bit (ignored while term_i is high)
//   term_i         : termination step, input forced to m0 so feedback is 0
//   sys_o          : systematic bit actually fed to the trellis
//   par_o          : parity bit for this step
//   state_o        : current trellis state {m1, m0}
module rsc_core
  import turbo_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       step_i,
  input  logic       u_i,
  input  logic       term_i,
  output logic       sys_o,
  output logic       par_o,
  output logic [1:0] state_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       u_eff;

  always_comb begin
    // Choosing u = m0 during the tail zeroes the feedback, flushing the state.
    u_eff   = term_i ? state_q[0] : u_i;
    state_d = state_q;
    if (clear_i) begin
      state_d = 2'b00;
    end else if (step_i) begin
      state_d = rsc_next(state_q, u_eff);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= 2'b00;
    end else begin
      state_q <= state_d;
    end
  end

  assign sys_o   = u_eff;
  assign par_o   = rsc_parity(state_q, u_eff);
  assign state_o = state_q;

endmodule

// File: rtl/turbo_encoder.sv
// Parallel-concatenated turbo encoder: a 5-bit block is encoded by two
// identical terminated 4-state RSC encoders, the second on interleaved
// order, producing four 7-symbol soft-symbol buses.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   read_en_i      : start request, honoured only while idle
//   data_i         : message, u[k] = data_i[k], latched at acceptance
//   sys_o, enc1_o  : natural-order systematic (with tail) and parity
//   sys2_o, enc2_o : interleaved systematic (with tail) and parity
//   busy_o         : block being encoded
//   finish_o       : one-cycle pulse, buses are final
module turbo_encoder
  import turbo_pkg::*;
#(
  // pi(i) = PERM[3i+2:3i]
  parameter logic [3*INPUT_SIZE-1:0] PERM = {3'd2, 3'd1, 3'd4, 3'd0, 3'd3}
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  read_en_i,
  input  logic [INPUT_SIZE-1:0] data_i,
  output logic [BUS_W-1:0]      sys_o,
  output logic [BUS_W-1:0]      enc1_o,
  output logic [BUS_W-1:0]      sys2_o,
  output logic [BUS_W-1:0]      enc2_o,
  output logic                  busy_o,
  output logic                  finish_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXTEND_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_MSG  = CNT_W'(INPUT_SIZE);

  fsm_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [INPUT_SIZE-1:0] data_q;
  logic [BUS_W-1:0]      sys_q, enc1_q, sys2_q, enc2_q;
  logic                  busy_q, finish_q;

  // Interleaved message, fixed by the permutation table.
  logic [INPUT_SIZE-1:0] data_pi;
  for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_interleave
    assign data_pi[gi] = data_q[PERM[3*gi +: 3]];
  end

  logic       in_msg;
  logic       rsc_step, rsc_clear;
  logic       u1, u2;
  logic       sys1_bit, par1_bit, sys2_bit, par2_bit;
  logic [1:0] rsc1_state, rsc2_state;

  assign in_msg    = (cnt_q < CNT_MSG);
  assign u1        = in_msg ? data_q[cnt_q]  : 1'b0;
  assign u2        = in_msg ? data_pi[cnt_q] : 1'b0;
  assign rsc_step  = (state_q == ST_ENCODE);
  assign rsc_clear = (state_q == ST_IDLE) && read_en_i;

  rsc_core u_rsc1 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (rsc_clear),
    .step_i  (rsc_step),
    .u_i     (u1),
    .term_i  (!in_msg),
    .sys_o   (sys1_bit),
    .par_o   (par1_bit),
    .state_o (rsc1_state)
  );

  rsc_core u_rsc2 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (rsc_clear),
    .step_i  (rsc_step),
    .u_i     (u2),
    .term_i  (!in_msg),
    .sys_o   (sys2_bit),
    .par_o   (par2_bit),
    .state_o (rsc2_state)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      sys_q    <= '0;
      enc1_q   <= '0;
      sys2_q   <= '0;
      enc2_q   <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          finish_q <= 1'b0;
          if (read_en_i) begin
            data_q  <= data_i;
            cnt_q   <= '0;
            sys_q   <= '0;
            enc1_q  <= '0;
            sys2_q  <= '0;
            enc2_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          sys_q [sym_lsb(cnt_q) +: SYM_W] <= bit_to_sym(sys1_bit);
          enc1_q[sym_lsb(cnt_q) +: SYM_W] <= bit_to_sym(par1_bit);
          sys2_q[sym_lsb(cnt_q) +: SYM_W] <= bit_to_sym(sys2_bit);
          enc2_q[sym_lsb(cnt_q) +: SYM_W] <= bit_to_sym(par2_bit);
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Start requests are not honoured here; IDLE samples them next.
          finish_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Termination must have flushed both trellises by the time the block ends.
  always @(posedge clk_i) begin
    if (!reset_i && state_q == ST_DONE) begin
      assert (rsc1_state == 2'b00 && rsc2_state == 2'b00);
    end
  end

  assign sys_o    = sys_q;
  assign enc1_o   = enc1_q;
  assign sys2_o   = sys2_q;
  assign enc2_o   = enc2_q;
  assign busy_o   = busy_q;
  assign finish_o = finish_q;

endmodule

// File: tb/tb_turbo_encoder.sv
module tb_turbo_encoder;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        read_en_i = 1'b0;
  logic [4:0]  data_i = 5'd0;
  logic [27:0] sys_o, enc1_o, sys2_o, enc2_o;
  logic        busy_o, finish_o;

  turbo_encoder dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .read_en_i (read_en_i),
    .data_i    (data_i),
    .sys_o     (sys_o),
    .enc1_o    (enc1_o),
    .sys2_o    (sys2_o),
    .enc2_o    (enc2_o),
    .busy_o    (busy_o),
    .finish_o  (finish_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [27:0] sys;
    logic [27:0] enc1;
    logic [27:0] sys2;
    logic [27:0] enc2;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk_bus(input string name, input logic [27:0] act, input logic [27:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: encode by walking the trellis arithmetically, symbol by symbol.
  function automatic exp_t model(input logic [4:0] d);
    int   pi_tab[5] = '{3, 0, 4, 1, 2};
    int   msg[5];
    int   s, m0, m1, u, a;
    logic [27:0] sb, pb;
    exp_t r;
    r.acc = 0;
    for (int e = 0; e < 2; e++) begin
      for (int k = 0; k < 5; k++) msg[k] = (e == 0) ? int'(d[k]) : int'(d[pi_tab[k]]);
      s = 0; sb = '0; pb = '0;
      for (int k = 0; k < 7; k++) begin
        m0 = s % 2;
        m1 = s / 2;
        u  = (k < 5) ? msg[k] : m0;
        a  = (u + m0) % 2;
        sb = {sb[23:0], (u == 1) ? 4'h7 : 4'h9};
        pb = {pb[23:0], (a == 1) ? 4'h7 : 4'h9};
        s  = 2 * a + m1;
      end
      if (e == 0) begin r.sys = sb; r.enc1 = pb; end
      else        begin r.sys2 = sb; r.enc2 = pb; end
    end
    return r;
  endfunction

  // Monitor: every finish_o pulse must match the oldest outstanding block.
  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_i && finish_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_finish: finish_o=1 with no block outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk_bus("sys_o", sys_o, e.sys);
        chk_bus("enc1_o", enc1_o, e.enc1);
        chk_bus("sys2_o", sys2_o, e.sys2);
        chk_bus("enc2_o", enc2_o, e.enc2);
        chk_int("latency", cyc - e.acc, 7);
        chk_int("busy_at_finish", int'(busy_o), 0);
        $display("block acc@%0d sys=%h enc1=%h sys2=%h enc2=%h", e.acc, sys_o, enc1_o, sys2_o, enc2_o);
      end
    end
  end

  // One block from IDLE back to IDLE. pulse_cyc in 1..7 raises read_en_i
  // before that ENCODE edge; pulse_done raises it during DONE.
  task automatic run_block(input logic [4:0] d, input exp_t ex, input int pulse_cyc,
                           input bit pulse_done, input bit toggle);
    data_i = d;
    read_en_i = 1'b1;
    @(posedge clk_i); #1;
    ex.acc = cyc;
    exp_q.push_back(ex);
    read_en_i = 1'b0;
    chk_int("busy_after_accept", int'(busy_o), 1);
    for (int j = 1; j <= 7; j++) begin
      if (toggle) data_i = 5'($urandom);
      read_en_i = (j == pulse_cyc);
      @(posedge clk_i); #1;
    end
    read_en_i = pulse_done;
    if (toggle) data_i = 5'($urandom);
    @(posedge clk_i); #1;
    read_en_i = 1'b0;
    chk_int("busy_idle", int'(busy_o), 0);
    chk_bus("hold_sys", sys_o, ex.sys);
    chk_bus("hold_enc2", enc2_o, ex.enc2);
  endtask

  initial begin
    exp_t ex;
    logic [4:0] d;
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $finish;
  end

  initial begin
    exp_t ex;
    logic [4:0] d;

    // Reset state
    #3;
    chk_bus("rst_sys", sys_o, 28'h0);
    chk_bus("rst_enc1", enc1_o, 28'h0);
    chk_bus("rst_sys2", sys2_o, 28'h0);
    chk_bus("rst_enc2", enc2_o, 28'h0);
    chk_int("rst_busy", int'(busy_o), 0);
    chk_int("rst_finish", int'(finish_o), 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed vectors with known encodings
    ex.sys = 28'h9999999; ex.enc1 = 28'h9999999; ex.sys2 = 28'h9999999; ex.enc2 = 28'h9999999; ex.acc = 0;
    run_block(5'b00000, ex, 0, 1'b0, 1'b0);
    ex.sys = 28'h7999997; ex.enc1 = 28'h7979799; ex.sys2 = 28'h9799979; ex.enc2 = 28'h9797999;
    run_block(5'b00001, ex, 0, 1'b0, 1'b0);

    // Abort in the 3rd ENCODE cycle: no finish may follow
    data_i = 5'b10110;
    read_en_i = 1'b1;
    @(posedge clk_i); #1;
    read_en_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    #1;
    chk_bus("abort_sys", sys_o, 28'h0);
    chk_bus("abort_enc1", enc1_o, 28'h0);
    chk_bus("abort_sys2", sys2_o, 28'h0);
    chk_bus("abort_enc2", enc2_o, 28'h0);
    chk_int("abort_busy", int'(busy_o), 0);
    chk_int("abort_finish", int'(finish_o), 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;

    // Encoding after abort
    ex.sys = 28'h7999997; ex.enc1 = 28'h7979799; ex.sys2 = 28'h9799979; ex.enc2 = 28'h9797999;
    run_block(5'b00001, ex, 0, 1'b0, 1'b0);

    // read_en_i held high: accepts on edges 0, 9, 18, ...
    read_en_i = 1'b1;
    for (int k = 0; k < 45; k++) begin
      d = 5'($urandom);
      data_i = d;
      @(posedge clk_i); #1;
      if (k % 9 == 0) begin
        ex = model(d);
        ex.acc = cyc;
        exp_q.push_back(ex);
      end
    end
    read_en_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;

    // Random blocks with data toggling and ignored start pulses
    for (int n = 0; n < 1000; n++) begin
      d = 5'($urandom);
      ex = model(d);
      run_block(d, ex, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (12) @(posedge clk_i);
    #1;
    chk_int("outstanding_blocks", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
